// File: rtl/seq_mult_core.sv
// seq_mult_core: radix-2 shift-add multiplier, one iteration per clock, registered 2W-bit product.
// Define SEQ_MULT_SIGNED_EN for two's complement operands (adds a NEG cycle when the product is negative).
module seq_mult_core #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] prod
);
  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
`ifdef SEQ_MULT_SIGNED_EN
    , NEG = 2'd3
`endif
  } state_t;

  state_t         state_reg;
  logic [2*W-1:0] acc_reg;
  logic [2*W-1:0] prod_reg;
  logic [W-1:0]   mcand_reg;
  logic [CW-1:0]  cnt_reg;
  logic           busy_reg;
  logic           done_reg;
  logic [W-1:0]   a_load;
  logic [W-1:0]   b_load;
  logic [W:0]     sum_next;
  logic [2*W-1:0] acc_next;

`ifdef SEQ_MULT_SIGNED_EN
  logic neg_reg;
  logic neg_load;

  // Magnitudes are taken as unsigned, so -2^(W-1) maps cleanly onto 2^(W-1).
  assign a_load   = a[W-1] ? -a : a;
  assign b_load   = b[W-1] ? -b : b;
  assign neg_load = a[W-1] ^ b[W-1];
`else
  assign a_load = a;
  assign b_load = b;
`endif

  // Upper half accumulates; lower half is the multiplier shifting out LSB-first.
  assign sum_next = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, mcand_reg} : '0);
  assign acc_next = {sum_next, acc_reg[W-1:1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      prod_reg  <= '0;
      mcand_reg <= '0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
`ifdef SEQ_MULT_SIGNED_EN
      neg_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            mcand_reg <= a_load;
            acc_reg   <= {{W{1'b0}}, b_load};
            cnt_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= CALC;
`ifdef SEQ_MULT_SIGNED_EN
            neg_reg   <= neg_load;
`endif
          end
        end
        CALC: begin
          acc_reg <= acc_next;
          cnt_reg <= cnt_reg + 1'b1;
          if (cnt_reg == LAST) begin
            prod_reg <= acc_next;
`ifdef SEQ_MULT_SIGNED_EN
            if (neg_reg) begin
              state_reg <= NEG;
            end else begin
              busy_reg  <= 1'b0;
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end
`else
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= DONE;
`endif
          end
        end
`ifdef SEQ_MULT_SIGNED_EN
        NEG: begin
          prod_reg  <= -prod_reg;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b1;
          state_reg <= DONE;
        end
`endif
        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign prod = prod_reg;

endmodule

// File: tb/tb_seq_mult_core.sv
// Self-checking bench for seq_mult_core: scoreboard of expected products and latencies.
// Honours SEQ_MULT_SIGNED_EN the same way as the design.
module tb_seq_mult_core;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] prod;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int prev_done_cyc = -1;
  int last_done_cyc = -1;

  typedef struct {
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [2*W-1:0] prod;
    int             acc_cyc;
    int             lat;
  } exp_t;

  exp_t sb[$];

  seq_mult_core #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .prod  (prod)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SEQ_MULT_SIGNED_EN
    return 64'(longint'($signed(x)) * longint'($signed(y)));
`else
    return 64'(x) * 64'(y);
`endif
  endfunction

  function automatic int lat_of(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SEQ_MULT_SIGNED_EN
    return (x[W-1] ^ y[W-1]) ? W + 1 : W;
`else
    return W;
`endif
  endfunction

  function automatic void push(input logic [W-1:0] x, input logic [W-1:0] y, input int c);
    exp_t e;
    e.op_a    = x;
    e.op_b    = y;
    e.prod    = model(x, y);
    e.acc_cyc = c;
    e.lat     = lat_of(x, y);
    sb.push_back(e);
  endfunction

  // Scoreboard consumer: every done strobe must match the oldest accepted request.
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && done === 1'b1) begin
      prev_done_cyc = last_done_cyc;
      last_done_cyc = cyc;
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        $display("[TB] 0x%08h * 0x%08h -> prod=0x%016h (exp 0x%016h) latency=%0d", e.op_a, e.op_b, prod, e.prod, cyc - e.acc_cyc);
        check("prod", prod, e.prod);
        check("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
      end
    end
  end

  // Assumes the DUT is idle in the next cycle; start is seen at exactly one edge.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    push(x, y, cyc);
  endtask

  task automatic wait_done(output int nbusy);
    bit seen;
    seen  = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
      else if (busy === 1'b1) nbusy++;
    end
    check("done_seen", 64'(seen), 64'd1);
  endtask

  task automatic run(input logic [W-1:0] x, input logic [W-1:0] y);
    int nb;
    issue(x, y);
    wait_done(nb);
    check("busy_cycles", 64'(nb), 64'(lat_of(x, y)));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int nb;
    int k;
    reset = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_prod", prod, 64'd0);
    reset = 1'b1;

    run(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(32'h1234_5678, 32'h0);
    run(32'h0, 32'h7);
    run(32'hDEAD_BEEF, 32'h0000_0013);

    // Load a nonzero product, then reset after 10 iterations of a new multiply.
    run(32'h0000_0123, 32'h0000_0456);
    issue(32'hFFFF_FFFF, 32'h3);
    repeat (10) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_prod", prod, 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run(32'd3, 32'd5);

    // Stray start pulses while busy must be ignored.
    issue(32'h0000_00FF, 32'h0000_0101);
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      if (c == 5 || c == 15 || c == 30) begin
        start = 1'b1;
        a = $urandom;
        b = $urandom;
      end else begin
        start = 1'b0;
      end
    end
    wait_done(nb);
    repeat (45) @(negedge clk);

    // start held high: second accept lands on the edge after DONE ends.
    @(negedge clk);
    a = 32'd2;
    b = 32'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    push(32'd2, 32'd3, cyc);
    k = cyc;
    @(negedge clk);
    a = 32'd4;
    b = 32'd5;
    wait_done(nb);
    @(posedge clk);
    @(posedge clk);
    #1;
    push(32'd4, 32'd5, cyc);
    start = 1'b0;
    a = 32'hFFFF_FFFF;
    b = 32'hFFFF_FFFF;
    wait_done(nb);
    @(posedge clk);
    #1;
    check("done_spacing", 64'(last_done_cyc - prev_done_cyc), 64'(W + 2));
    check("b2b_total", 64'(last_done_cyc - k), 64'(2 * W + 2));

`ifdef SEQ_MULT_SIGNED_EN
    run(32'hFFFF_FFFD, 32'd7);
    check("signed_neg21", prod, 64'hFFFF_FFFF_FFFF_FFEB);
    run(32'h8000_0000, 32'h8000_0000);
    check("signed_min_sq", prod, 64'h4000_0000_0000_0000);
    run(32'h8000_0000, 32'h0000_0001);
`endif

    repeat (5) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_mult_core.md
# seq_mult_core

Sequential radix-2 shift-add multiplier that computes the 64-bit product consumed by the 32-bit multiplier slot peripheral. The slot wrapper supplies the two registered multiplicands and pulses `start`. This core then produces a registered product plus a `done` strobe, which the wrapper latches into its readable upper and lower words. The core trades the combinational multiply for one iteration per clock, with a fixed, deterministic latency.

## Interface
- `W`, default 32: operand width; product width is 2·W.
- `clk`  in  1: system clock; all state updates on rising edge.
- `reset`  in  1: asynchronous, active-low reset; asserting it (0) clears all state immediately.
- `start`  in  1: request; sampled only in IDLE.
- `a`  in  W: multiplicand; sampled on the accepting edge only.
- `b`  in  W: multiplier; sampled on the accepting edge only.
- `busy`  out  1: high while a multiply is in progress (CALC, NEG).
- `done`  out  1: single-cycle strobe; `prod` is valid and stable from this cycle on.
- `prod`  out  2·W: registered product; holds the last result until the next completion.

## Operation
- Internal registers:
  - `acc`: 2·W-bit accumulator, upper half plus multiplier shift register.
  - `mcand`: W-bit multiplicand.
  - `cnt`: $clog2(W)+1 bits.
  - `neg`: sign flag.
  - `prod`.
  - `state`.
- IDLE:
  - If `start`=1: `mcand`←a and `acc`←{W'0, b}; `cnt`←0; go to CALC.
  - Otherwise hold.
- CALC, one iteration per cycle:
  - sum = {1'b0, acc[2W-1:W]} + (acc[0] ? mcand : 0), computed W+1 bits wide.
  - `acc`←{sum, acc[W-1:1]}.
  - `cnt`++.
  - On the iteration where `cnt`=W−1: write the final `acc` into `prod` and go to DONE, or to NEG when signed mode is compiled in and `neg`=1.
- NEG (signed build only): `prod`←−`prod` as a 2·W two's complement negate; go to DONE.
- DONE: `done`=1 for this cycle only; go to IDLE unconditionally.
- `start` outside IDLE is ignored; there is no queueing. The wrapper must wait for `done` (or for `busy`=0) before the next `start`.
- `prod` changes only on entry to DONE (or NEG). It never shows partial sums.
- Arithmetic is exact. Unsigned max: (2^W−1)² fits in 2·W with no overflow.
- Operand changes on `a`/`b` after the accepting edge have no effect.

## Timing
- Reset values: `busy`=0, `done`=0, `prod`=0, state IDLE, `cnt`=0, `acc`=0.
- `start` is accepted at edge k.
  - `busy`=1 from k until DONE is entered.
  - Unsigned build: `done`=1 in the cycle after edge k+W, i.e. 32 cycles after acceptance for W=32. `busy` falls at that same edge.
  - Signed build: the NEG cycle adds one, giving k+W+1, but only when `neg`=1. The signed build has variable latency W or W+1.
- Back-to-back: the earliest next accept is the edge ending the DONE cycle, i.e. a `start` held high during DONE is taken as IDLE is entered one edge later. Throughput is one product per W+2 cycles.
- Reset mid-operation: immediately returns to reset values. `prod` is cleared and no `done` is issued.
- `start`=1 held continuously: a new multiply begins every W+2 cycles using the `a`/`b` present at each accepting edge.

## Configuration
- `SEQ_MULT_SIGNED_EN` defined:
  - Operands are W-bit two's complement.
  - At accept: `neg`←a[W-1]^b[W-1]; `mcand`←|a|; multiplier←|b|.
  - Negation via a NEG state as above.
  - −2^(W−1) is handled as an unsigned magnitude 2^(W−1). (−2^31)·(−2^31) = 0x4000_0000_0000_0000.
- `SEQ_MULT_SIGNED_EN` undefined: unsigned only. There is no NEG state and no `neg` register, and latency is always W.

## Test plan
- Reset asserted during CALC (after 10 iterations) → `busy`=0, `done`=0, `prod`=0 immediately; a subsequent start 3×5 → `prod`=15.
- Unsigned: a=0xFFFF_FFFF, b=0xFFFF_FFFF → `done` exactly 32 cycles after accept, `prod`=0xFFFF_FFFE_0000_0001; `busy` high for 32 cycles.
- a=0x1234_5678, b=0 → `prod`=0. Then a=0, b=7 → `prod`=0. Latency is unchanged at 32.
- `start` pulsed at cycles 5, 15 and 30 after a first accept → only the first is taken; one `done`; `prod` reflects the first operands.
- Back-to-back with `start` held high: 2×3 then 4×5 → `done` strobes 34 cycles apart; `prod`=6, then 20.
- Signed build: a=−3 (0xFFFF_FFFD), b=7 → `prod`=0xFFFF_FFFF_FFFF_FFEB (−21) with latency 33. a=−2^31, b=−2^31 → 0x4000_0000_0000_0000 with latency 32.
